wb_pipe_regfile: RTL

Write-back side of the MIPS integer pipeline. It consumes the write-back triplet the EX stage produces (`w_reg_addr`/`w_reg_data`/`w_reg_en`) and carries it through the EX/MEM and MEM/WB pipeline registers. At the end of MEM/WB it commits the value into the 32×32 general register file. It also serves the two ID-stage operand read ports, with full forwarding from EX, MEM and WB.

---
 rtl/wb_pipe_regfile_pkg.sv | 37 +++
 rtl/wb_pipe_regfile_if.sv | 39 +++
 rtl/wb_pipe_regfile_regfile_core.sv | 41 ++++
 rtl/wb_pipe_regfile.sv | 101 ++++++++++
 4 files changed

// File: rtl/wb_pipe_regfile_pkg.sv
// ==================================================================
// wb_pipe_regfile_pkg : register-file widths and read-source select
// Revision 1.0
// ==================================================================
`default_nettype none

package wb_pipe_regfile_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 32;

  localparam logic [REG_DATA_WIDTH-1:0] ZERO_WORD    = '0;
  localparam logic [REG_ADDR_WIDTH-1:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [2:0] {
    SRC_ZERO  = 3'd0,
    SRC_EX    = 3'd1,
    SRC_S1    = 3'd2,
    SRC_S2    = 3'd3,
    SRC_ARRAY = 3'd4
  } rd_src_e;

  // Youngest producer wins; r0 and disabled ports never forward.
  function automatic rd_src_e rd_src_sel(input logic en, input logic addr_zero,
                                         input logic ex_hit, input logic s1_hit,
                                         input logic s2_hit);
    if (!en || addr_zero) return SRC_ZERO;
    else if (ex_hit)      return SRC_EX;
    else if (s1_hit)      return SRC_S1;
    else if (s2_hit)      return SRC_S2;
    else                  return SRC_ARRAY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_pipe_regfile_if.sv
// ==================================================================
// wb_pipe_regfile_if : EX write-back, ID read ports and WB stage view
// Revision 1.0
// ==================================================================
`default_nettype none

interface wb_pipe_regfile_if #(
  parameter int DATA_W = wb_pipe_regfile_pkg::REG_DATA_WIDTH,
  parameter int ADDR_W = wb_pipe_regfile_pkg::REG_ADDR_WIDTH
);
  logic              ex_w_en;
  logic [ADDR_W-1:0] ex_w_addr;
  logic [DATA_W-1:0] ex_w_data;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd2_en;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic              wb_w_en;
  logic [ADDR_W-1:0] wb_w_addr;
  logic [DATA_W-1:0] wb_w_data;

  modport master (
    output ex_w_en, ex_w_addr, ex_w_data,
    output rd1_en, rd1_addr, rd2_en, rd2_addr,
    input  rd1_data, rd2_data,
    input  wb_w_en, wb_w_addr, wb_w_data
  );

  modport slave (
    input  ex_w_en, ex_w_addr, ex_w_data,
    input  rd1_en, rd1_addr, rd2_en, rd2_addr,
    output rd1_data, rd2_data,
    output wb_w_en, wb_w_addr, wb_w_data
  );
endinterface

`default_nettype wire

// File: rtl/wb_pipe_regfile_regfile_core.sv
// ==================================================================
// regfile_core : general register array, one sync write, two comb reads
// Revision 1.0
// ==================================================================
`default_nettype none

module regfile_core
  import wb_pipe_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int NREG   = REG_NUM
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr1,
  input  wire logic [ADDR_W-1:0] raddr2,
  output logic      [DATA_W-1:0] rdata1,
  output logic      [DATA_W-1:0] rdata2
);

  // r0 has no storage at all; it is synthesised as a constant zero.
  logic [DATA_W-1:0] r_mem [1:NREG-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) r_mem[i] <= DATA_W'(ZERO_WORD);
    end else if (we && (waddr != ADDR_W'(NOP_REG_ADDR))) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == ADDR_W'(NOP_REG_ADDR)) ? DATA_W'(ZERO_WORD) : r_mem[raddr1];
  assign rdata2 = (raddr2 == ADDR_W'(NOP_REG_ADDR)) ? DATA_W'(ZERO_WORD) : r_mem[raddr2];

endmodule

`default_nettype wire

// File: rtl/wb_pipe_regfile.sv
// ==================================================================
// wb_pipe_regfile : EX/MEM and MEM/WB write-back stages, register file, forwarding
// Revision 1.0
// ==================================================================
`default_nettype none

module wb_pipe_regfile
  import wb_pipe_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int ADDR_W = REG_ADDR_WIDTH,
  parameter int NREG   = REG_NUM
) (
  input wire logic          clk,
  input wire logic          rst_n,
  input wire logic          stall,
  input wire logic          flush,
  wb_pipe_regfile_if.slave  bus
);

  logic              r_s1_en,   r_s2_en;
  logic [ADDR_W-1:0] r_s1_addr, r_s2_addr;
  logic [DATA_W-1:0] r_s1_data, r_s2_data;

  logic              w_ex_en;
  logic [ADDR_W-1:0] w_ex_addr;
  logic [DATA_W-1:0] w_ex_data;
  logic [DATA_W-1:0] w_arr1, w_arr2;

  assign w_ex_en   = bus.ex_w_en;
  assign w_ex_addr = bus.ex_w_addr;
  assign w_ex_data = bus.ex_w_data;

  // Flush outranks stall; a stall freezes S1 and feeds S2 a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_s1_en   <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
      r_s2_en   <= 1'b0;
      r_s2_addr <= '0;
      r_s2_data <= '0;
    end else if (stall) begin
      r_s2_en   <= 1'b0;
      r_s2_addr <= '0;
      r_s2_data <= '0;
    end else begin
      r_s1_en   <= w_ex_en;
      r_s1_addr <= w_ex_addr;
      r_s1_data <= w_ex_data;
      r_s2_en   <= r_s1_en;
      r_s2_addr <= r_s1_addr;
      r_s2_data <= r_s1_data;
    end
  end

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (r_s2_en),
    .waddr  (r_s2_addr),
    .wdata  (r_s2_data),
    .raddr1 (bus.rd1_addr),
    .raddr2 (bus.rd2_addr),
    .rdata1 (w_arr1),
    .rdata2 (w_arr2)
  );

  function automatic logic [DATA_W-1:0] fwd_mux(input logic              en,
                                                input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] arr);
    rd_src_e src;
    src = rd_src_sel(en, addr == '0,
                     w_ex_en && (w_ex_addr == addr),
                     r_s1_en && (r_s1_addr == addr),
                     r_s2_en && (r_s2_addr == addr));
    case (src)
      SRC_EX:    fwd_mux = w_ex_data;
      SRC_S1:    fwd_mux = r_s1_data;
      SRC_S2:    fwd_mux = r_s2_data;
      SRC_ARRAY: fwd_mux = arr;
      default:   fwd_mux = '0;
    endcase
  endfunction

  always_comb begin
    bus.rd1_data = fwd_mux(bus.rd1_en, bus.rd1_addr, w_arr1);
    bus.rd2_data = fwd_mux(bus.rd2_en, bus.rd2_addr, w_arr2);
  end

  assign bus.wb_w_en   = r_s2_en;
  assign bus.wb_w_addr = r_s2_addr;
  assign bus.wb_w_data = r_s2_data;

endmodule

`default_nettype wire
